// File: rtl/udp_reg_arbiter.sv
// Round-robin arbiter that shares the single UDP core register port between NUM_REQ requesters.
// One transaction is outstanding at a time; completion data and ack go to the granted requester only.
module udp_reg_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int REQ_ID_WIDTH = 1,
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_req,
  input  logic [NUM_REQ-1:0]        req_rd_wr_L,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rd_data,
  output logic                      core_reg_req,
  output logic                      core_reg_rd_wr_L,
  output logic [ADDR_W-1:0]         core_reg_addr,
  output logic [DATA_W-1:0]         core_reg_wr_data,
  input  logic                      core_reg_ack,
  input  logic [DATA_W-1:0]         core_reg_rd_data,
  output logic [REQ_ID_WIDTH-1:0]   grant_id,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [REQ_ID_WIDTH-1:0] r_rr_ptr;
  logic [REQ_ID_WIDTH-1:0] r_grant_id;
  logic [REQ_ID_WIDTH-1:0] w_winner;
  logic                    w_any;
  logic                    w_gnt_req;
  logic                    w_start;
  logic                    w_done;
  logic                    w_abort;
  logic                    r_core_req;
  logic                    r_core_rd_wr_L;
  logic [ADDR_W-1:0]       r_core_addr;
  logic [DATA_W-1:0]       r_core_wr_data;
  logic [DATA_W-1:0]       r_rd_data;
  logic [NUM_REQ-1:0]      r_req_ack;

  function automatic logic [REQ_ID_WIDTH-1:0] next_id(input logic [REQ_ID_WIDTH-1:0] id);
    if (int'(id) >= NUM_REQ - 1) return '0;
    return id + REQ_ID_WIDTH'(1);
  endfunction

  // First requesting index at or after the rr pointer, wrapping back to 0.
  always_comb begin
    logic [REQ_ID_WIDTH-1:0] cand;
    w_any    = 1'b0;
    w_winner = '0;
    cand     = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_req[cand]) begin
        w_any    = 1'b1;
        w_winner = cand;
      end
      cand = next_id(cand);
    end
  end

  assign w_gnt_req = req_req[r_grant_id];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A completing ack wins over a same-cycle abort: the access already happened.
        if (core_reg_ack) begin
          w_done      = 1'b1;
          w_state_nxt = RELEASE;
        end else if (!w_gnt_req) begin
          w_abort     = 1'b1;
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!w_gnt_req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_core_req     <= 1'b0;
      r_core_rd_wr_L <= 1'b0;
      r_core_addr    <= '0;
      r_core_wr_data <= '0;
      r_grant_id     <= '0;
      r_rr_ptr       <= '0;
      r_rd_data      <= '0;
      r_req_ack      <= '0;
    end else begin
      r_req_ack <= '0;
      if (w_start) begin
        r_core_req     <= 1'b1;
        r_core_rd_wr_L <= req_rd_wr_L[w_winner];
        r_core_addr    <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
        r_core_wr_data <= req_wr_data[int'(w_winner)*DATA_W +: DATA_W];
        r_grant_id     <= w_winner;
      end
      if (w_done) begin
        r_rd_data  <= core_reg_rd_data;
        r_req_ack  <= NUM_REQ'(1) << r_grant_id;
        r_core_req <= 1'b0;
        r_rr_ptr   <= next_id(r_grant_id);
      end
      if (w_abort) begin
        r_core_req <= 1'b0;
        r_rr_ptr   <= next_id(r_grant_id);
      end
    end
  end

  assign req_ack          = r_req_ack;
  assign req_rd_data      = r_rd_data;
  assign core_reg_req     = r_core_req;
  assign core_reg_rd_wr_L = r_core_rd_wr_L;
  assign core_reg_addr    = r_core_addr;
  assign core_reg_wr_data = r_core_wr_data;
  assign grant_id         = r_grant_id;
  assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_udp_reg_arbiter.sv
// Directed self-checking bench for udp_reg_arbiter with two requesters and a hand-driven register master.
module tb_udp_reg_arbiter;
  localparam int NUM_REQ      = 2;
  localparam int REQ_ID_WIDTH = 1;
  localparam int ADDR_W       = 23;
  localparam int DATA_W       = 32;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_req;
  logic [NUM_REQ-1:0]        req_rd_wr_L;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wr_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         req_rd_data;
  logic                      core_reg_req;
  logic                      core_reg_rd_wr_L;
  logic [ADDR_W-1:0]         core_reg_addr;
  logic [DATA_W-1:0]         core_reg_wr_data;
  logic                      core_reg_ack;
  logic [DATA_W-1:0]         core_reg_rd_data;
  logic [REQ_ID_WIDTH-1:0]   grant_id;
  logic                      busy;

  int checks = 0;
  int errors = 0;

  udp_reg_arbiter #(
    .NUM_REQ(NUM_REQ), .REQ_ID_WIDTH(REQ_ID_WIDTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_req(req_req), .req_rd_wr_L(req_rd_wr_L), .req_addr(req_addr), .req_wr_data(req_wr_data),
    .req_ack(req_ack), .req_rd_data(req_rd_data),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_ack(core_reg_ack), .core_reg_rd_data(core_reg_rd_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_rd_wr_L[id]               = rd;
    req_addr[id*ADDR_W +: ADDR_W] = a;
    req_wr_data[id*DATA_W +: DATA_W] = d;
  endtask

  // Ticks until core_reg_req is seen high; n = ticks taken, or -1 when the budget runs out.
  task automatic wait_core_req(output int n);
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (core_reg_req === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Master ack pulse sampled on the next posedge; leaves the bench at the following negedge.
  task automatic master_ack(input logic [DATA_W-1:0] d);
    core_reg_ack     = 1'b1;
    core_reg_rd_data = d;
    tick();
    core_reg_ack     = 1'b0;
    core_reg_rd_data = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_req = '0; req_rd_wr_L = '0; req_addr = '0; req_wr_data = '0;
    core_reg_ack = 1'b0; core_reg_rd_data = '0;
    tick(); tick();
    checks++;
    if ({core_reg_req, core_reg_rd_wr_L, req_ack, busy, grant_id} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000", {core_reg_req, core_reg_rd_wr_L, req_ack, busy, grant_id});
    end
    checks++;
    if ({core_reg_addr, core_reg_wr_data, req_rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h exp 0", core_reg_addr, core_reg_wr_data, req_rd_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int n;
    set_req(0, 1'b1, 23'h000040, 32'h0);
    req_req[0] = 1'b1;
    wait_core_req(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL rd_latency got %0d exp 1", n); end
    checks++;
    if ({core_reg_rd_wr_L, core_reg_addr, grant_id, busy} !== {1'b1, 23'h000040, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rd_drive got rw=%b addr=%h gid=%0d busy=%b exp rw=1 addr=000040 gid=0 busy=1",
               core_reg_rd_wr_L, core_reg_addr, grant_id, busy);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({core_reg_req, req_ack} !== 3'b100) begin
        errors++;
        $display("FAIL rd_hold got %b exp 100", {core_reg_req, req_ack});
      end
    end
    master_ack(32'h1234_5678);
    checks++;
    if ({req_ack, core_reg_req} !== 3'b010 || req_rd_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_ack got ack=%b req=%b data=%h exp ack=01 req=0 data=12345678",
               req_ack, core_reg_req, req_rd_data);
    end
    req_req[0] = 1'b0;
    tick();
    checks++;
    if ({req_ack, busy} !== 3'b000 || req_rd_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rd_after got ack=%b busy=%b data=%h exp ack=00 busy=0 data=12345678",
               req_ack, busy, req_rd_data);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic exp;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    set_req(0, 1'b1, 23'h000100, 32'h0);
    set_req(1, 1'b1, 23'h000200, 32'h0);
    for (int p = 0; p < 2; p++) begin
      req_req = 2'b11;
      for (int t = 0; t < 2; t++) begin
        exp = (t == 1);
        wait_core_req(n);
        checks++;
        if (n !== (t == 0 ? 1 : 2)) begin
          errors++;
          $display("FAIL rr_gap p%0d t%0d got %0d exp %0d", p, t, n, (t == 0 ? 1 : 2));
        end
        checks++;
        if (grant_id !== exp || core_reg_addr !== (exp ? 23'h000200 : 23'h000100)) begin
          errors++;
          $display("FAIL rr_grant p%0d t%0d got gid=%0d addr=%h exp gid=%0d", p, t, grant_id, core_reg_addr, exp);
        end
        master_ack(32'h0000_1000 + 32'(p * 2 + t));
        checks++;
        if (req_ack !== (exp ? 2'b10 : 2'b01) || req_rd_data !== 32'h0000_1000 + 32'(p * 2 + t)) begin
          errors++;
          $display("FAIL rr_ack p%0d t%0d got ack=%b data=%h exp ack=%b", p, t, req_ack, req_rd_data,
                   (exp ? 2'b10 : 2'b01));
        end
        req_req[exp] = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_write_hold();
    int n;
    set_req(1, 1'b0, 23'h000010, 32'hA5A5_A5A5);
    req_req[1] = 1'b1;
    wait_core_req(n);
    checks++;
    if (n !== 1 || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant got n=%0d gid=%0d exp n=1 gid=1", n, grant_id);
    end
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'(i), 23'(32'h3_0000 + i), 32'hC0DE_0000 + 32'(i));
      tick();
      checks++;
      if ({core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data} !==
          {1'b1, 1'b0, 23'h000010, 32'hA5A5_A5A5}) begin
        errors++;
        $display("FAIL wr_hold c%0d got req=%b rw=%b addr=%h data=%h exp 1/0/000010/a5a5a5a5",
                 i, core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data);
      end
    end
    master_ack(32'h0);
    checks++;
    if (req_ack !== 2'b10 || core_reg_req !== 1'b0) begin
      errors++;
      $display("FAIL wr_ack got ack=%b req=%b exp ack=10 req=0", req_ack, core_reg_req);
    end
    req_req[1] = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int n;
    set_req(0, 1'b1, 23'h000044, 32'h0);
    set_req(1, 1'b1, 23'h000048, 32'h0);
    req_req[0] = 1'b1;
    wait_core_req(n);
    checks++;
    if (n !== 1 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL ab_grant got n=%0d gid=%0d exp n=1 gid=0", n, grant_id);
    end
    req_req[1] = 1'b1;
    tick(); tick();
    req_req[0] = 1'b0;
    tick();
    checks++;
    if ({core_reg_req, req_ack, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL ab_drop got req=%b ack=%b busy=%b exp req=0 ack=00 busy=1", core_reg_req, req_ack, busy);
    end
    wait_core_req(n);
    checks++;
    if (n !== 2 || grant_id !== 1'b1 || core_reg_addr !== 23'h000048 || req_ack !== 2'b00) begin
      errors++;
      $display("FAIL ab_next got n=%0d gid=%0d addr=%h ack=%b exp n=2 gid=1 addr=000048 ack=00",
               n, grant_id, core_reg_addr, req_ack);
    end
    master_ack(32'h0BAD_F00D);
    checks++;
    if (req_ack !== 2'b10 || req_rd_data !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL ab_ack got ack=%b data=%h exp ack=10 data=0badf00d", req_ack, req_rd_data);
    end
    req_req[1] = 1'b0;
    tick();
  endtask

  task automatic test_timeout_data();
    int n;
    master_ack(32'h5555_5555);
    checks++;
    if (req_ack !== 2'b00 || req_rd_data !== 32'h0BAD_F00D || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack got ack=%b data=%h busy=%b exp ack=00 data=0badf00d busy=0",
               req_ack, req_rd_data, busy);
    end
    set_req(0, 1'b1, 23'h7FFFFF, 32'h0);
    req_req[0] = 1'b1;
    wait_core_req(n);
    checks++;
    if (n !== 1 || core_reg_addr !== 23'h7FFFFF) begin
      errors++;
      $display("FAIL to_drive got n=%0d addr=%h exp n=1 addr=7fffff", n, core_reg_addr);
    end
    master_ack(32'hDEAD_0000);
    checks++;
    if (req_ack !== 2'b01 || req_rd_data !== 32'hDEAD_0000) begin
      errors++;
      $display("FAIL to_data got ack=%b data=%h exp ack=01 data=dead0000", req_ack, req_rd_data);
    end
    req_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int n;
    set_req(0, 1'b1, 23'h000020, 32'h1111_1111);
    set_req(1, 1'b1, 23'h000024, 32'h2222_2222);
    req_req[0] = 1'b1;
    wait_core_req(n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL ar_grant got %0d exp 1", n); end
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({core_reg_req, busy, req_ack} !== 4'b0 || core_reg_addr !== '0 || req_rd_data !== '0) begin
      errors++;
      $display("FAIL ar_async got req=%b busy=%b ack=%b addr=%h data=%h exp all 0",
               core_reg_req, busy, req_ack, core_reg_addr, req_rd_data);
    end
    tick();
    master_ack(32'h7777_7777);
    checks++;
    if (req_ack !== 2'b00) begin errors++; $display("FAIL ar_noack got %b exp 00", req_ack); end
    req_req = 2'b00;
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, core_reg_req} !== 2'b00) begin
      errors++;
      $display("FAIL ar_idle got busy=%b req=%b exp 0/0", busy, core_reg_req);
    end
    req_req = 2'b11;
    wait_core_req(n);
    checks++;
    if (n !== 1 || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL ar_ptr got n=%0d gid=%0d exp n=1 gid=0", n, grant_id);
    end
    master_ack(32'h0000_00A0);
    checks++;
    if (req_ack !== 2'b01) begin errors++; $display("FAIL ar_ack0 got %b exp 01", req_ack); end
    req_req[0] = 1'b0;
    wait_core_req(n);
    checks++;
    if (n !== 2 || grant_id !== 1'b1) begin
      errors++;
      $display("FAIL ar_next got n=%0d gid=%0d exp n=2 gid=1", n, grant_id);
    end
    master_ack(32'h0000_00A1);
    checks++;
    if (req_ack !== 2'b10 || req_rd_data !== 32'h0000_00A1) begin
      errors++;
      $display("FAIL ar_ack1 got ack=%b data=%h exp ack=10 data=000000a1", req_ack, req_rd_data);
    end
    req_req[1] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_hold();
    test_abort();
    test_timeout_data();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
